// File: rtl/seg_capture_pkg.sv
// seg_capture_pkg: shared constants and types for the 7-segment scan-bus capture.
package seg_capture_pkg;
   localparam int DIGITS = 6;
   localparam logic [2:0] SEL_IDLE = 3'd6;
   localparam logic [6:0] SEG_PAT [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };
   typedef struct packed {
      logic       err;
      logic [3:0] nib;
   } dec_t;
endpackage

// File: rtl/seg_capture_if.sv
// seg_capture_if: scan-bus inputs and decoded-frame outputs of the capture block.
interface seg_capture_if;
   import seg_capture_pkg::*;
   logic [2:0]          sel_in;
   logic [7:0]          seg_in;
   logic [4*DIGITS-1:0] data_out;
   logic [DIGITS-1:0]   dp_out;
   logic                frame_valid;
   logic                frame_err;
   logic                frame_changed;
   logic                frame_lost;
   modport master (
      output sel_in, seg_in,
      input  data_out, dp_out, frame_valid, frame_err, frame_changed, frame_lost
   );
   modport slave (
      input  sel_in, seg_in,
      output data_out, dp_out, frame_valid, frame_err, frame_changed, frame_lost
   );
endinterface

// File: rtl/seg_capture_decode.sv
// seg_capture_decode: active-high a..g pattern to hex nibble; unknown patterns flag err.
module seg_capture_decode
   import seg_capture_pkg::*;
(
   input  logic [6:0] i_pat,
   output dec_t       o_dec
);
   always_comb begin
      o_dec = '{err: 1'b1, nib: 4'd0};
      for (int k = 0; k < 16; k++)
         if (i_pat == SEG_PAT[k]) o_dec = '{err: 1'b0, nib: 4'(k)};
   end
endmodule

// File: rtl/seg_capture.sv
// seg_capture: samples the multiplexed sel/seg scan bus and rebuilds the 6-digit display word.
module seg_capture
   import seg_capture_pkg::*;
#(
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter int STABLE_CYC     = 16,
   parameter int TIMEOUT_CYC    = 200000
) (
   input logic           clk,
   input logic           rst,
   seg_capture_if.slave  bus
);
   localparam int SW = $clog2(STABLE_CYC);
   localparam int TW = $clog2(TIMEOUT_CYC);
   logic [2:0]          r_sel, r_sel_d;
   logic [7:0]          r_seg, r_seg_d;
   logic [SW-1:0]       r_stab;
   logic [TW-1:0]       r_to;
   logic [4*DIGITS-1:0] r_nib, r_data;
   logic [DIGITS-1:0]   r_dp, r_err, r_map, r_dpo;
   logic                r_valid, r_ferr, r_changed, r_lost;
   dec_t                w_dec;
   logic                w_same, w_acc, w_full, w_exp, w_clr;
   logic [DIGITS-1:0]   w_bit;
   seg_capture_decode u_dec (.i_pat(r_seg[6:0]), .o_dec(w_dec));
   // accept on the transition into the saturated count, so each dwell yields one accept
   assign w_same = {r_sel, r_seg} == {r_sel_d, r_seg_d};
   assign w_acc  = w_same && r_stab == SW'(STABLE_CYC - 2) && r_sel < SEL_IDLE;
   assign w_full = &r_map;
   assign w_exp  = |r_map && !w_full && !w_acc && r_to == TW'(TIMEOUT_CYC - 1);
   assign w_clr  = w_full || w_exp;
   assign w_bit  = w_acc ? DIGITS'(1) << r_sel : '0;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sel     <= '0;
         r_sel_d   <= '0;
         r_seg     <= '0;
         r_seg_d   <= '0;
         r_stab    <= '0;
         r_to      <= '0;
         r_nib     <= '0;
         r_dp      <= '0;
         r_err     <= '0;
         r_map     <= '0;
         r_data    <= '0;
         r_dpo     <= '0;
         r_valid   <= 1'b0;
         r_ferr    <= 1'b0;
         r_changed <= 1'b0;
         r_lost    <= 1'b0;
      end else begin
         r_sel   <= bus.sel_in;
         r_seg   <= SEG_ACTIVE_LOW ? ~bus.seg_in : bus.seg_in;
         r_sel_d <= r_sel;
         r_seg_d <= r_seg;
         r_stab  <= !w_same ? '0 : r_stab == SW'(STABLE_CYC - 1) ? r_stab : r_stab + 1'b1;
         if (w_acc) begin
            r_nib[{r_sel, 2'b00} +: 4] <= w_dec.nib;
            r_dp[r_sel]                <= r_seg[7];
         end
         r_map     <= (w_clr ? '0 : r_map) | w_bit;
         r_err     <= ((w_clr ? '0 : r_err) & ~w_bit) | ({DIGITS{w_dec.err}} & w_bit);
         r_to      <= (w_acc || w_clr || r_map == '0) ? '0 : r_to + 1'b1;
         r_valid   <= w_full;
         r_lost    <= w_exp;
         r_changed <= w_full && {r_nib, r_dp} != {r_data, r_dpo};
         if (w_full) begin
            r_data <= r_nib;
            r_dpo  <= r_dp;
            r_ferr <= |r_err;
         end
      end
   end
   assign bus.data_out      = r_data;
   assign bus.dp_out        = r_dpo;
   assign bus.frame_valid   = r_valid;
   assign bus.frame_err     = r_ferr;
   assign bus.frame_changed = r_changed;
   assign bus.frame_lost    = r_lost;
endmodule
